// File: rtl/axi_mm2s_pkg.sv
// Shared types and constants for the AXI4 memory-mapped to stream mux bridge.
package axi_mm2s_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WrIdle,
        WrData,
        WrResp
    } wr_state_e;

    typedef enum logic {
        RdIdle,
        RdData
    } rd_state_e;

    // Channel field width; a single channel still needs one tdest bit.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered stream stage; payload holds steady while valid waits for ready.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 256,
    parameter int DEST_WIDTH = 2
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_keep,
    input  logic [DEST_WIDTH-1:0]   in_dest,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [DATA_WIDTH/8-1:0] out_keep,
    output logic [DEST_WIDTH-1:0]   out_dest,
    output logic                    out_last
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_dest  <= '0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_keep <= in_keep;
                out_dest <= in_dest;
                out_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/axi_mm2s_mux_bridge.sv
// AXI4 slave: write bursts go to a tdest-tagged output stream, read bursts are served
// from one of several input streams; channel chosen by an address field.
module axi_mm2s_mux_bridge
    import axi_mm2s_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_CH     = 4,
    parameter int CH_SEL_LSB = 12,
    parameter int CH_W       = ch_width(NUM_CH)
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [ID_WIDTH-1:0]          s_axi_awid,
    input  logic [63:0]                  s_axi_awaddr,
    input  logic [7:0]                   s_axi_awlen,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
    input  logic                         s_axi_wlast,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [ID_WIDTH-1:0]          s_axi_bid,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ID_WIDTH-1:0]          s_axi_arid,
    input  logic [63:0]                  s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [ID_WIDTH-1:0]          s_axi_rid,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
    output logic [CH_W-1:0]              m_axis_tdest,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]            s_axis_tvalid,
    output logic [NUM_CH-1:0]            s_axis_tready,
    output logic [15:0]                  wr_err_cnt,
    output logic [15:0]                  rd_burst_cnt
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    // Address bits outside the channel field are don't-care.
    logic unused_addr;
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    // ---------------- Write path ----------------
    wr_state_e             wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0]   awid_q;
    logic [7:0]            awlen_q;
    logic [CH_W-1:0]       wch_q;
    logic                  woor_q;
    logic [8:0]            wbeats_q;
    logic                  werr_q;
    logic [CH_W-1:0]       aw_ch;
    logic [8:0]            wbeats_next;
    logic                  aw_hs, w_hs, b_hs, w_done, slice_in_ready;

    assign aw_ch       = s_axi_awaddr[CH_SEL_LSB +: CH_W];
    assign wbeats_next = wbeats_q + 9'd1;

    assign s_axi_awready = (wr_state_q == WrIdle) && !areset;
    assign s_axi_wready  = (wr_state_q == WrData) && slice_in_ready;
    assign s_axi_bvalid  = (wr_state_q == WrResp);
    assign s_axi_bid     = awid_q;
    assign s_axi_bresp   = (s_axi_bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign b_hs   = s_axi_bvalid && s_axi_bready;
    // A runaway burst is cut off at the AXI4 maximum of 256 beats.
    assign w_done = w_hs && (s_axi_wlast || (wbeats_next == 9'd256));

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WrIdle:  if (aw_hs)  wr_state_d = WrData;
            WrData:  if (w_done) wr_state_d = WrResp;
            WrResp:  if (b_hs)   wr_state_d = WrIdle;
            default: wr_state_d = WrIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= WrIdle;
            awid_q     <= '0;
            awlen_q    <= '0;
            wch_q      <= '0;
            woor_q     <= 1'b0;
            wbeats_q   <= '0;
            werr_q     <= 1'b0;
            wr_err_cnt <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) begin
                awid_q   <= s_axi_awid;
                awlen_q  <= s_axi_awlen;
                wch_q    <= aw_ch;
                woor_q   <= ({1'b0, aw_ch} >= NUM_CH_L);
                wbeats_q <= '0;
            end else if (w_hs) begin
                wbeats_q <= wbeats_next;
            end
            if (w_done) begin
                werr_q <= woor_q || (wbeats_next != ({1'b0, awlen_q} + 9'd1));
            end
            if (b_hs && werr_q && (wr_err_cnt != 16'hFFFF)) begin
                wr_err_cnt <= wr_err_cnt + 16'd1;
            end
        end
    end

    // Out-of-range beats are swallowed: accepted on W but never presented downstream.
    axis_reg_slice #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEST_WIDTH(CH_W)
    ) u_out_slice (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (w_hs && !woor_q),
        .in_ready  (slice_in_ready),
        .in_data   (s_axi_wdata),
        .in_keep   (s_axi_wstrb),
        .in_dest   (wch_q),
        .in_last   (s_axi_wlast),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (m_axis_tdata),
        .out_keep  (m_axis_tkeep),
        .out_dest  (m_axis_tdest),
        .out_last  (m_axis_tlast)
    );

    // ---------------- Read path ----------------
    rd_state_e             rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]   arid_q;
    logic [7:0]            arlen_q;
    logic [CH_W-1:0]       rch_q;
    logic                  roor_q;
    logic [7:0]            rbeats_q;
    logic [CH_W-1:0]       ar_ch;
    logic                  ar_hs, r_hs, rd_active;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;

    assign ar_ch     = s_axi_araddr[CH_SEL_LSB +: CH_W];
    assign rd_active = (rd_state_q == RdData);

    always_comb begin
        sel_valid     = 1'b0;
        sel_data      = '0;
        s_axis_tready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rch_q == CH_W'(c)) begin
                sel_valid        = s_axis_tvalid[c];
                sel_data         = s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH];
                s_axis_tready[c] = rd_active && !roor_q && s_axi_rready;
            end
        end
    end

    assign s_axi_arready = (rd_state_q == RdIdle) && !areset;
    assign s_axi_rvalid  = rd_active && (roor_q || sel_valid);
    assign s_axi_rdata   = (rd_active && !roor_q) ? sel_data : '0;
    assign s_axi_rresp   = (rd_active && roor_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast   = rd_active && (rbeats_q == arlen_q);
    assign s_axi_rid     = arid_q;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RdIdle:  if (ar_hs) rd_state_d = RdData;
            RdData:  if (r_hs && s_axi_rlast) rd_state_d = RdIdle;
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_q   <= RdIdle;
            arid_q       <= '0;
            arlen_q      <= '0;
            rch_q        <= '0;
            roor_q       <= 1'b0;
            rbeats_q     <= '0;
            rd_burst_cnt <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_hs) begin
                arid_q   <= s_axi_arid;
                arlen_q  <= s_axi_arlen;
                rch_q    <= ar_ch;
                roor_q   <= ({1'b0, ar_ch} >= NUM_CH_L);
                rbeats_q <= '0;
            end else if (r_hs) begin
                rbeats_q <= rbeats_q + 8'd1;
            end
            if (r_hs && s_axi_rlast && (rd_burst_cnt != 16'hFFFF)) begin
                rd_burst_cnt <= rd_burst_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_mm2s_mux_bridge.sv
// Directed bench: a 4-channel bridge plus a 3-channel one sharing its inputs for range errors.
module tb_axi_mm2s_mux_bridge;

    localparam int DW    = 32;
    localparam int BOUND = 200;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [3:0]   awid = '0, arid = '0;
    logic [63:0]  awaddr = '0, araddr = '0;
    logic [7:0]   awlen = '0, arlen = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
    logic         arvalid = 1'b0, rready = 1'b0, m_tready = 1'b1;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic [127:0] s_tdata = '0;
    logic [3:0]   s_tvalid = '0;

    logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a, rlast_a;
    logic        m_tlast_a, m_tvalid_a;
    logic [3:0]  bid_a, rid_a, m_tkeep_a, s_tready_a;
    logic [1:0]  bresp_a, rresp_a, m_tdest_a;
    logic [31:0] rdata_a, m_tdata_a;
    logic [15:0] wr_err_cnt_a, rd_burst_cnt_a;

    logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b, rlast_b;
    logic        m_tlast_b, m_tvalid_b;
    logic [3:0]  bid_b, rid_b, m_tkeep_b;
    logic [2:0]  s_tready_b;
    logic [1:0]  bresp_b, rresp_b, m_tdest_b;
    logic [31:0] rdata_b, m_tdata_b;
    logic [15:0] wr_err_cnt_b, rd_burst_cnt_b;

    int errors = 0;
    int checks = 0;
    bit tog = 1'b0;
    bit b_tvalid_seen = 1'b0;
    logic [38:0] mq_a[$], mq_b[$], rq_a[$], rq_b[$];

    always #5 aclk = ~aclk;

    axi_mm2s_mux_bridge #(.DATA_WIDTH(DW), .ID_WIDTH(4), .NUM_CH(4), .CH_SEL_LSB(12)) dut_a (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready_a),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready_a),
        .s_axi_bid(bid_a), .s_axi_bresp(bresp_a), .s_axi_bvalid(bvalid_a), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready_a),
        .s_axi_rid(rid_a), .s_axi_rdata(rdata_a), .s_axi_rresp(rresp_a), .s_axi_rlast(rlast_a),
        .s_axi_rvalid(rvalid_a), .s_axi_rready(rready),
        .m_axis_tdata(m_tdata_a), .m_axis_tkeep(m_tkeep_a), .m_axis_tdest(m_tdest_a),
        .m_axis_tlast(m_tlast_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tready(m_tready),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_a),
        .wr_err_cnt(wr_err_cnt_a), .rd_burst_cnt(rd_burst_cnt_a)
    );

    axi_mm2s_mux_bridge #(.DATA_WIDTH(DW), .ID_WIDTH(4), .NUM_CH(3), .CH_SEL_LSB(12)) dut_b (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready_b),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready_b),
        .s_axi_bid(bid_b), .s_axi_bresp(bresp_b), .s_axi_bvalid(bvalid_b), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready_b),
        .s_axi_rid(rid_b), .s_axi_rdata(rdata_b), .s_axi_rresp(rresp_b), .s_axi_rlast(rlast_b),
        .s_axi_rvalid(rvalid_b), .s_axi_rready(rready),
        .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tdest(m_tdest_b),
        .m_axis_tlast(m_tlast_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready),
        .s_axis_tdata(s_tdata[95:0]), .s_axis_tvalid(s_tvalid[2:0]), .s_axis_tready(s_tready_b),
        .wr_err_cnt(wr_err_cnt_b), .rd_burst_cnt(rd_burst_cnt_b)
    );

    // Handshake monitor, sampled 1 time unit before each rising edge.
    initial forever begin
        @(negedge aclk);
        #4;
        if (!areset) begin
            if (m_tvalid_a && m_tready) mq_a.push_back({m_tdest_a, m_tlast_a, m_tkeep_a, m_tdata_a});
            if (m_tvalid_b && m_tready) mq_b.push_back({m_tdest_b, m_tlast_b, m_tkeep_b, m_tdata_b});
            if (m_tvalid_b) b_tvalid_seen = 1'b1;
            if (rvalid_a && rready) rq_a.push_back({rid_a, rresp_a, rlast_a, rdata_a});
            if (rvalid_b && rready) rq_b.push_back({rid_b, rresp_b, rlast_b, rdata_b});
        end
    end

    initial forever begin
        @(negedge aclk);
        if (tog) m_tready = ~m_tready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] wdat(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic logic [3:0] wstb(input int i);
        case (i % 4)
            0:       return 4'hF;
            1:       return 4'h3;
            2:       return 4'hC;
            default: return 4'h1;
        endcase
    endfunction

    // All handshake tasks start and end just after a falling edge.
    task automatic aw_hs(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        #1;
        while (!awready_a && n < BOUND) begin @(negedge aclk); #1; n++; end
        checks++;
        if (n >= BOUND) begin errors++; $display("FAIL aw_timeout: got awready=0 required 1"); end
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic w_hs(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        #1;
        while (!wready_a && n < BOUND) begin @(negedge aclk); #1; n++; end
        checks++;
        if (n >= BOUND) begin errors++; $display("FAIL w_timeout: got wready=0 required 1"); end
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic ar_hs(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        #1;
        while (!arready_a && n < BOUND) begin @(negedge aclk); #1; n++; end
        checks++;
        if (n >= BOUND) begin errors++; $display("FAIL ar_timeout: got arready=0 required 1"); end
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic b_take(input int hold, output logic [3:0] bid_o,
                          output logic [1:0] ra_o, output logic [1:0] rb_o);
        int n = 0;
        bit ok = 1'b1;
        bready = 1'b0;
        #1;
        while (!bvalid_a && n < BOUND) begin @(negedge aclk); #1; n++; end
        checks++;
        if (n >= BOUND) begin errors++; $display("FAIL b_timeout: got bvalid=0 required 1"); end
        bid_o = bid_a; ra_o = bresp_a; rb_o = bresp_b;
        for (int i = 0; i < hold; i++) begin
            @(negedge aclk); #1;
            if (!bvalid_a || bid_a !== bid_o || awready_a !== 1'b0) ok = 1'b0;
        end
        if (hold > 0) begin
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b_hold: got bvalid/bid/awready unstable, required bvalid=1 bid=%h awready=0",
                         bid_o);
            end
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int nbeats, input int hold, output logic [3:0] bid_o,
                            output logic [1:0] ra_o, output logic [1:0] rb_o);
        fork
            aw_hs(id, addr, len);
            begin
                for (int i = 0; i < nbeats; i++) w_hs(wdat(i), wstb(i), i == nbeats - 1);
            end
        join
        b_take(hold, bid_o, ra_o, rb_o);
        repeat (3) @(negedge aclk);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input int ch, input bit rnd, output bit bad_tready);
        bad_tready = 1'b0;
        fork
            ar_hs(id, addr, len);
            begin
                int n = 0;
                while (rq_a.size() < int'(len) + 1 && n < BOUND * 4) begin
                    rready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
                    s_tvalid[ch] = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
                    s_tdata[ch*32 +: 32] = 32'hA000_0000 + 32'(rq_a.size());
                    #1;
                    if ((s_tready_a & ~(4'b0001 << ch)) != 4'b0000) bad_tready = 1'b1;
                    @(negedge aclk);
                    n++;
                end
                rready = 1'b0; s_tvalid = '0;
                checks++;
                if (n >= BOUND * 4) begin
                    errors++;
                    $display("FAIL r_timeout: got %0d beats required %0d", rq_a.size(), int'(len) + 1);
                end
            end
        join
        @(negedge aclk);
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({awready_a, wready_a, bvalid_a, bid_a, bresp_a, arready_a, rvalid_a, rid_a, rdata_a,
             rresp_a, rlast_a, m_tdata_a, m_tkeep_a, m_tdest_a, m_tlast_a, m_tvalid_a, s_tready_a,
             wr_err_cnt_a, rd_burst_cnt_a} != '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs (awready=%b arready=%b) required all 0",
                     awready_a, arready_a);
        end
        @(negedge aclk);
        areset = 1'b0;
        #1;
        checks++;
        if ({awready_a, arready_a, wready_a, bvalid_a, rvalid_a} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_release: got aw/ar/w/b/r=%b required 11000",
                     {awready_a, arready_a, wready_a, bvalid_a, rvalid_a});
        end
        @(negedge aclk);
    endtask

    task automatic test_write_basic(input int hold, input bit toggle_ready);
        logic [3:0]  bid;
        logic [1:0]  ra, rb;
        logic [38:0] exp;
        mq_a.delete();
        tog = toggle_ready;
        wr_burst(4'h5, 64'h2000, 8'd3, 4, hold, bid, ra, rb);
        tog = 1'b0; m_tready = 1'b1;
        repeat (3) @(negedge aclk);
        checks++;
        if (mq_a.size() != 4) begin
            errors++; $display("FAIL wr_beats: got %0d beats required 4", mq_a.size());
        end
        for (int i = 0; i < 4 && i < mq_a.size(); i++) begin
            exp = {2'd2, i == 3, wstb(i), wdat(i)};
            checks++;
            if (mq_a[i] !== exp) begin
                errors++; $display("FAIL wr_beat%0d: got %h required %h", i, mq_a[i], exp);
            end
        end
        checks++;
        if (bid !== 4'h5 || ra !== 2'b00) begin
            errors++; $display("FAIL wr_bresp: got bid=%h bresp=%b required bid=5 bresp=00", bid, ra);
        end
        checks++;
        if (awready_a !== 1'b1) begin
            errors++; $display("FAIL wr_awready_after_b: got %b required 1", awready_a);
        end
    endtask

    task automatic test_short_burst;
        logic [3:0] bid;
        logic [1:0] ra, rb;
        mq_a.delete();
        wr_burst(4'h4, 64'h2000, 8'd3, 2, 0, bid, ra, rb);
        checks++;
        if (mq_a.size() != 2 || mq_a[mq_a.size()-1][36] !== 1'b1) begin
            errors++; $display("FAIL short_beats: got %0d beats required 2 ending in tlast", mq_a.size());
        end
        checks++;
        if (ra !== 2'b10 || wr_err_cnt_a !== 16'd1) begin
            errors++;
            $display("FAIL short_bresp: got bresp=%b err_cnt=%0d required bresp=10 err_cnt=1",
                     ra, wr_err_cnt_a);
        end
    endtask

    task automatic test_read_gapped;
        bit bad;
        logic [38:0] exp;
        rq_a.delete(); rq_b.delete();
        rd_burst(4'h9, 64'h1000, 8'd7, 1, 1'b1, bad);
        checks++;
        if (rq_a.size() != 8) begin
            errors++; $display("FAIL rd_beats: got %0d beats required 8", rq_a.size());
        end
        for (int i = 0; i < 8 && i < rq_a.size(); i++) begin
            exp = {4'h9, 2'b00, i == 7, 32'hA000_0000 + 32'(i)};
            checks++;
            if (rq_a[i] !== exp) begin
                errors++; $display("FAIL rd_beat%0d: got %h required %h", i, rq_a[i], exp);
            end
        end
        checks++;
        if (bad) begin errors++; $display("FAIL rd_other_tready: got nonzero required 0"); end
        checks++;
        if (rd_burst_cnt_a !== 16'd1) begin
            errors++; $display("FAIL rd_burst_cnt: got %0d required 1", rd_burst_cnt_a);
        end
    endtask

    task automatic test_out_of_range;
        logic [3:0]  bid;
        logic [1:0]  ra, rb;
        logic [38:0] exp;
        bit bad;
        mq_b.delete(); rq_a.delete(); rq_b.delete();
        b_tvalid_seen = 1'b0;
        wr_burst(4'h2, 64'h3000, 8'd1, 2, 0, bid, ra, rb);
        checks++;
        if (b_tvalid_seen || mq_b.size() != 0) begin
            errors++; $display("FAIL oor_tvalid: got tvalid raised required never");
        end
        checks++;
        if (rb !== 2'b10 || wr_err_cnt_b !== 16'd2) begin
            errors++;
            $display("FAIL oor_bresp: got bresp=%b err_cnt=%0d required bresp=10 err_cnt=2",
                     rb, wr_err_cnt_b);
        end
        rd_burst(4'h6, 64'h3000, 8'd1, 3, 1'b0, bad);
        checks++;
        if (rq_b.size() != 2) begin
            errors++; $display("FAIL oor_rd_beats: got %0d beats required 2", rq_b.size());
        end
        for (int i = 0; i < 2 && i < rq_b.size(); i++) begin
            exp = {4'h6, 2'b10, i == 1, 32'h0};
            checks++;
            if (rq_b[i] !== exp) begin
                errors++; $display("FAIL oor_rd_beat%0d: got %h required %h", i, rq_b[i], exp);
            end
        end
        checks++;
        if (s_tready_b !== 3'b000 || rd_burst_cnt_b !== 16'd2) begin
            errors++; $display("FAIL oor_rd_state: got tready=%b cnt=%0d required 000 and 2",
                               s_tready_b, rd_burst_cnt_b);
        end
    endtask

    task automatic test_reset_midflight;
        logic [3:0]  bid;
        logic [1:0]  ra, rb;
        logic [38:0] exp;
        fork
            aw_hs(4'h3, 64'h1000, 8'd3);
            begin w_hs(wdat(0), wstb(0), 1'b0); w_hs(wdat(1), wstb(1), 1'b0); end
        join
        m_tready = 1'b0;
        ar_hs(4'h7, 64'h1000, 8'd3);
        s_tvalid[1] = 1'b1;
        #1;
        checks++;
        if (m_tvalid_a !== 1'b1 || rvalid_a !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got tvalid=%b rvalid=%b required 1 1",
                               m_tvalid_a, rvalid_a);
        end
        #2 areset = 1'b1;
        #1;
        checks++;
        if ({awready_a, wready_a, bvalid_a, bid_a, bresp_a, arready_a, rvalid_a, rid_a, rdata_a,
             rresp_a, rlast_a, m_tdata_a, m_tkeep_a, m_tdest_a, m_tlast_a, m_tvalid_a, s_tready_a,
             wr_err_cnt_a, rd_burst_cnt_a, awready_b, m_tvalid_b, rvalid_b, rd_burst_cnt_b,
             wr_err_cnt_b} != '0) begin
            errors++;
            $display("FAIL midflight_reset: got tvalid=%b rvalid=%b rid=%h errcnt=%0d required all 0",
                     m_tvalid_a, rvalid_a, rid_a, wr_err_cnt_a);
        end
        @(negedge aclk);
        areset = 1'b0; s_tvalid = '0; m_tready = 1'b1;
        mq_a.delete();
        @(negedge aclk);
        wr_burst(4'h1, 64'h0000, 8'd0, 1, 0, bid, ra, rb);
        exp = {2'd0, 1'b1, wstb(0), wdat(0)};
        checks++;
        if (mq_a.size() != 1 || mq_a[0] !== exp) begin
            errors++; $display("FAIL post_reset_beat: got %0d beats first %h required 1 beat %h",
                               mq_a.size(), mq_a.size() ? mq_a[0] : 39'h0, exp);
        end
        checks++;
        if (bid !== 4'h1 || ra !== 2'b00) begin
            errors++; $display("FAIL post_reset_b: got bid=%h bresp=%b required 1 00", bid, ra);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic(0, 1'b0);
        test_write_basic(10, 1'b1);
        test_short_burst();
        test_read_gapped();
        test_out_of_range();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
